chrom_run_scheduler: RTL and testbench
======================================

# chrom_run_scheduler

Sequences one chromosome evaluation run between the HPS-side PIO handshake and the chromosome processing state machine. It converts the HPS level-signal protocol (start, done, ack) into the processing FSM's ready/start/done/feedback handshake. It latches the sequence count for the duration of a run and counts completed runs. An optional watchdog aborts runs that stall. It sits between the PIO exports and `chromosomeProcessingStateMachine` in `top`.

## Interface
- `TIMEOUT_W`, default 24: width of the watchdog counter.
- `TIMEOUT_CYCLES`, default 24'd10_000_000: watchdog limit in clocks, counted per waiting state.
- `iClock` in 1: system clock (CLOCK_50).
- `iReset` in 1: reset, synchronous and active-high; one clock domain.
- `iHpsStart` in 1: HPS start request level (PIO).
- `iHpsAck` in 1: HPS acknowledge level (PIO).
- `oHpsDone` out 1: run finished or aborted, toward HPS.
- `iSequencesToProcess` in 8: requested sequence count (PIO).
- `oSequencesToProcess` out 8: count latched at run start, fed to the processing FSM.
- `iReadyToProcess` in 1: processing FSM ready.
- `oStartProcessing` out 1: start toward the processing FSM.
- `iDoneProcessing` in 1: processing FSM done.
- `oDoneProcessingFeedback` out 1: done acknowledge toward the processing FSM.
- `oBusy` out 1: high in any state except IDLE.
- `oTimeout` out 1: high in the ERROR state.
- `oRunCount` out 16: completed runs; saturates at 16'hFFFF.
- `oState` out 3: state encoding, for debug LEDs.

## Operation
- States and encodings: IDLE=0, WAIT_READY=1, START=2, RUN=3, FEEDBACK=4, REPORT=5, WAIT_RELEASE=6, ERROR=7.
- Outputs decode from the registered state:
  - `oStartProcessing` = START.
  - `oDoneProcessingFeedback` = FEEDBACK.
  - `oHpsDone` = REPORT | WAIT_RELEASE | ERROR.
- IDLE → WAIT_READY when `iHpsStart`=1 and `iHpsAck`=0. On that edge, latch `iSequencesToProcess` into `oSequencesToProcess`.
  - If the latched count is 0, go to REPORT instead. No processing occurs and `oRunCount` is unchanged.
- WAIT_READY → START when `iReadyToProcess`=1.
- START transitions:
  - → FEEDBACK if `iDoneProcessing`=1. This takes priority.
  - Otherwise → RUN when `iReadyToProcess`=0.
- RUN → FEEDBACK when `iDoneProcessing`=1.
- FEEDBACK → REPORT when `iDoneProcessing`=0. On this transition, `oRunCount` increments with saturation.
- REPORT → WAIT_RELEASE when `iHpsAck`=1.
- WAIT_RELEASE → IDLE when `iHpsStart`=0 and `iHpsAck`=0.
- Dropping `iHpsStart` after IDLE is ignored; the run completes.
- `oSequencesToProcess` holds its value until the next IDLE→WAIT_READY edge.
- ERROR exit:
  - → WAIT_RELEASE when `iHpsAck`=1.
  - `oStartProcessing` and `oDoneProcessingFeedback` are 0 in ERROR.
  - `oRunCount` is not incremented.

## Timing
- Reset values: state IDLE; `oHpsDone`, `oStartProcessing`, `oDoneProcessingFeedback`, `oBusy`, `oTimeout` = 0; `oSequencesToProcess`=0; `oRunCount`=0; `oState`=0.
- Reset applies on the clock edge where `iReset`=1, including mid-run. The processing FSM sees `oStartProcessing`/`oDoneProcessingFeedback` drop on that same edge.
- All inputs are sampled on the rising edge. Every transition takes 1 clock; there are no combinational input→output paths.
- Minimum latency, `iHpsStart` high (cycle 0) with `iReadyToProcess` already high:
  - WAIT_READY at cycle 1.
  - `oStartProcessing`=1 at cycle 2.
- `oStartProcessing` is high for at least 1 cycle. It stays high until the processing FSM drops ready or raises done.
- Watchdog:
  - Counter clears on every state change.
  - Counts while in WAIT_READY, START, RUN and FEEDBACK.
  - When it reaches `TIMEOUT_CYCLES`-1 without a transition, the next state is ERROR.
  - If the normal exit condition is true on that same cycle, the normal transition wins.

## Configuration
- `CHROM_SCHED_TIMEOUT_EN` defined: the watchdog counter and the ERROR state are built as described.
- Not defined:
  - No counter logic.
  - ERROR is unreachable.
  - `oTimeout` is tied to 0.
  - Waiting states wait indefinitely.
  - `TIMEOUT_W`/`TIMEOUT_CYCLES` are unused.

## Test plan
- Nominal run:
  - Stimulus: `iSequencesToProcess`=8'd12, ready=1, start pulse; processing FSM drops ready at +1 and asserts done 40 cycles later.
  - Required: `oStartProcessing` high at cycle 2; `oDoneProcessingFeedback` high until done drops; `oHpsDone`=1; after ack/release, IDLE; `oRunCount`=1; `oSequencesToProcess`=12 throughout.
- Zero count:
  - Stimulus: `iSequencesToProcess`=0, start.
  - Required: state 5 at cycle 1; `oStartProcessing` never asserted; `oRunCount` unchanged.
- Fast done:
  - Stimulus: done=1 in the first START cycle with ready still 1.
  - Required: next state FEEDBACK, RUN skipped.
- Watchdog (macro on, `TIMEOUT_CYCLES`=100):
  - Stimulus: ready held 0.
  - Required: ERROR after 100 cycles in WAIT_READY; `oTimeout`=1, `oHpsDone`=1; ack → WAIT_RELEASE; release → IDLE with `oTimeout`=0.
- Reset mid-RUN:
  - Stimulus: `iReset`=1 for 1 cycle during RUN, with `oRunCount`=5.
  - Required: next cycle all outputs at their reset values, `oRunCount`=0, state IDLE.
- Saturation:
  - Stimulus: preload via 65535 runs (or force), then one more run.
  - Required: `oRunCount` stays 16'hFFFF.

Source files
------------

// File: rtl/chrom_run_scheduler.sv
// chrom_run_scheduler: sequences one chromosome evaluation run between the HPS
// PIO level handshake (start/ack/done) and the processing FSM's
// ready/start/done/feedback handshake. It latches the sequence count for the
// duration of a run and keeps a saturating count of completed runs.
//
// Optional watchdog: define CHROM_SCHED_TIMEOUT_EN to build the per-state
// timeout counter and make the ERROR state reachable. Without it, the waiting
// states wait indefinitely and oTimeout is tied low.
module chrom_run_scheduler #(
  parameter int unsigned           TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iHpsStart,
  input  logic        iHpsAck,
  output logic        oHpsDone,
  input  logic [7:0]  iSequencesToProcess,
  output logic [7:0]  oSequencesToProcess,
  input  logic        iReadyToProcess,
  output logic        oStartProcessing,
  input  logic        iDoneProcessing,
  output logic        oDoneProcessingFeedback,
  output logic        oBusy,
  output logic        oTimeout,
  output logic [15:0] oRunCount,
  output logic [2:0]  oState
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_READY   = 3'd1,
    ST_START        = 3'd2,
    ST_RUN          = 3'd3,
    ST_FEEDBACK     = 3'd4,
    ST_REPORT       = 3'd5,
    ST_WAIT_RELEASE = 3'd6,
    ST_ERROR        = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_seq;
  logic [15:0] r_run_count;

`ifdef CHROM_SCHED_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_CYCLES - 1'b1;

  logic [TIMEOUT_W-1:0] r_wd_cnt;
  logic                 w_is_waiting;

  // Only the states that wait on the processing FSM are supervised.
  assign w_is_waiting = (r_state == ST_WAIT_READY) || (r_state == ST_START) ||
                        (r_state == ST_RUN)        || (r_state == ST_FEEDBACK);
`endif

  // Next-state logic: normal handshake first, watchdog overrides only a stall.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (iHpsStart && !iHpsAck)
          w_next = (iSequencesToProcess == 8'd0) ? ST_REPORT : ST_WAIT_READY;
      ST_WAIT_READY:
        if (iReadyToProcess) w_next = ST_START;
      ST_START:
        if (iDoneProcessing)       w_next = ST_FEEDBACK;  // fast done skips RUN
        else if (!iReadyToProcess) w_next = ST_RUN;
      ST_RUN:
        if (iDoneProcessing) w_next = ST_FEEDBACK;
      ST_FEEDBACK:
        if (!iDoneProcessing) w_next = ST_REPORT;
      ST_REPORT:
        if (iHpsAck) w_next = ST_WAIT_RELEASE;
      ST_WAIT_RELEASE:
        if (!iHpsStart && !iHpsAck) w_next = ST_IDLE;
      ST_ERROR:
        if (iHpsAck) w_next = ST_WAIT_RELEASE;
      default:
        w_next = ST_IDLE;
    endcase
`ifdef CHROM_SCHED_TIMEOUT_EN
    // A normal exit on the limit cycle wins; only a stall becomes ERROR.
    if (w_is_waiting && (w_next == r_state) && (r_wd_cnt == WD_LIMIT))
      w_next = ST_ERROR;
`endif
  end

  // State register, count latch and saturating run counter.
  always_ff @(posedge iClock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (iReset) begin
      r_state     <= ST_IDLE;
      r_seq       <= 8'd0;
      r_run_count <= 16'd0;
    end else begin
      r_state <= w_next;
      // Latch the count on leaving IDLE (also for a zero-count run).
      if ((r_state == ST_IDLE) && (w_next != ST_IDLE))
        r_seq <= iSequencesToProcess;
      // A run completes only through FEEDBACK -> REPORT.
      if ((r_state == ST_FEEDBACK) && (w_next == ST_REPORT) &&
          (r_run_count != 16'hFFFF))
        r_run_count <= r_run_count + 16'd1;
    end
  end

`ifdef CHROM_SCHED_TIMEOUT_EN
  // Watchdog: clears on any state change, counts while stuck in a waiting state.
  always_ff @(posedge iClock) begin
    if (iReset)
      r_wd_cnt <= '0;
    else if ((w_next != r_state) || !w_is_waiting)
      r_wd_cnt <= '0;
    else
      r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  assign oTimeout = (r_state == ST_ERROR);
`else
  // Watchdog parameters have no effect in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;

  assign oTimeout = 1'b0;
`endif

  assign oStartProcessing        = (r_state == ST_START);
  assign oDoneProcessingFeedback = (r_state == ST_FEEDBACK);
  assign oHpsDone                = (r_state == ST_REPORT) ||
                                   (r_state == ST_WAIT_RELEASE) ||
                                   (r_state == ST_ERROR);
  assign oBusy                   = (r_state != ST_IDLE);
  assign oSequencesToProcess     = r_seq;
  assign oRunCount               = r_run_count;
  assign oState                  = r_state;

endmodule

// File: tb/tb_chrom_run_scheduler.sv
// Directed self-checking bench for chrom_run_scheduler. Inputs change 1 ns
// after a rising edge and outputs are checked at the same point, so each
// step() is one DUT transition. The watchdog section adapts to whether
// CHROM_SCHED_TIMEOUT_EN is defined.
module tb_chrom_run_scheduler;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iHpsStart;
  logic        iHpsAck;
  logic        oHpsDone;
  logic [7:0]  iSequencesToProcess;
  logic [7:0]  oSequencesToProcess;
  logic        iReadyToProcess;
  logic        oStartProcessing;
  logic        iDoneProcessing;
  logic        oDoneProcessingFeedback;
  logic        oBusy;
  logic        oTimeout;
  logic [15:0] oRunCount;
  logic [2:0]  oState;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT_READY = 3'd1, S_START = 3'd2,
                         S_RUN = 3'd3, S_FEEDBACK = 3'd4, S_REPORT = 3'd5,
                         S_WAIT_RELEASE = 3'd6, S_ERROR = 3'd7;

  chrom_run_scheduler #(
    .TIMEOUT_W      (24),
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .iClock                  (iClock),
    .iReset                  (iReset),
    .iHpsStart               (iHpsStart),
    .iHpsAck                 (iHpsAck),
    .oHpsDone                (oHpsDone),
    .iSequencesToProcess     (iSequencesToProcess),
    .oSequencesToProcess     (oSequencesToProcess),
    .iReadyToProcess         (iReadyToProcess),
    .oStartProcessing        (oStartProcessing),
    .iDoneProcessing         (iDoneProcessing),
    .oDoneProcessingFeedback (oDoneProcessingFeedback),
    .oBusy                   (oBusy),
    .oTimeout                (oTimeout),
    .oRunCount               (oRunCount),
    .oState                  (oState)
  );

  always #5 iClock = ~iClock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  // Ack then release; scheduler must pass WAIT_RELEASE and land in IDLE.
  task automatic hps_release(input string tag);
    iHpsAck = 1'b1;
    step();
    check({tag, "_wait_release"}, oState, S_WAIT_RELEASE);
    check({tag, "_done_in_release"}, oHpsDone, 1'b1);
    iHpsStart = 1'b0;
    iHpsAck   = 1'b0;
    step();
    check({tag, "_idle"}, oState, S_IDLE);
    check({tag, "_done_low"}, oHpsDone, 1'b0);
  endtask

  // Shortest complete run: done raised in the first START cycle.
  task automatic quick_run(input string tag, input logic [15:0] exp_count);
    iSequencesToProcess = 8'd1;
    iReadyToProcess     = 1'b1;
    iHpsStart           = 1'b1;
    step();
    step();
    check({tag, "_start"}, oStartProcessing, 1'b1);
    iDoneProcessing = 1'b1;
    step();
    check({tag, "_feedback"}, oState, S_FEEDBACK);
    iDoneProcessing = 1'b0;
    step();
    check({tag, "_report"}, oState, S_REPORT);
    check({tag, "_count"}, oRunCount, exp_count);
    hps_release(tag);
  endtask

  initial begin
    iReset              = 1'b1;
    iHpsStart           = 1'b0;
    iHpsAck             = 1'b0;
    iSequencesToProcess = 8'd0;
    iReadyToProcess     = 1'b0;
    iDoneProcessing     = 1'b0;
    step();
    step();

    // ---- reset state ----
    check("rst_state", oState, S_IDLE);
    check("rst_busy", oBusy, 1'b0);
    check("rst_hps_done", oHpsDone, 1'b0);
    check("rst_start", oStartProcessing, 1'b0);
    check("rst_feedback", oDoneProcessingFeedback, 1'b0);
    check("rst_timeout", oTimeout, 1'b0);
    check("rst_seq", oSequencesToProcess, 8'd0);
    check("rst_count", oRunCount, 16'd0);
    iReset = 1'b0;
    step();
    check("idle_hold", oState, S_IDLE);

    // ---- nominal run, count 12 ----
    iSequencesToProcess = 8'd12;
    iReadyToProcess     = 1'b1;
    iHpsStart           = 1'b1;         // cycle 0
    step();                             // cycle 1
    check("nom_wait_ready", oState, S_WAIT_READY);
    check("nom_busy", oBusy, 1'b1);
    check("nom_start_c1", oStartProcessing, 1'b0);
    check("nom_seq_latched", oSequencesToProcess, 8'd12);
    iSequencesToProcess = 8'd99;        // later input changes must not leak
    step();                             // cycle 2
    check("nom_start_c2", oStartProcessing, 1'b1);
    check("nom_state_start", oState, S_START);
    iReadyToProcess = 1'b0;
    step();
    check("nom_run", oState, S_RUN);
    check("nom_start_drop", oStartProcessing, 1'b0);
    iHpsStart = 1'b0;                   // dropping start mid-run is ignored
    for (int i = 0; i < 38; i++) begin
      step();
      check("nom_run_hold", oState, S_RUN);
    end
    check("nom_seq_run", oSequencesToProcess, 8'd12);
    iDoneProcessing = 1'b1;
    step();
    check("nom_feedback", oDoneProcessingFeedback, 1'b1);
    check("nom_count_pre", oRunCount, 16'd0);
    step();
    step();
    check("nom_feedback_hold", oDoneProcessingFeedback, 1'b1);
    iDoneProcessing = 1'b0;
    step();
    check("nom_report", oState, S_REPORT);
    check("nom_feedback_drop", oDoneProcessingFeedback, 1'b0);
    check("nom_hps_done", oHpsDone, 1'b1);
    check("nom_count", oRunCount, 16'd1);
    hps_release("nom");
    check("nom_seq_after", oSequencesToProcess, 8'd12);
    check("nom_count_after", oRunCount, 16'd1);

    // ---- zero count ----
    iSequencesToProcess = 8'd0;
    iReadyToProcess     = 1'b1;
    iHpsStart           = 1'b1;
    step();
    check("zero_report", oState, S_REPORT);
    check("zero_seq", oSequencesToProcess, 8'd0);
    check("zero_start", oStartProcessing, 1'b0);
    check("zero_hps_done", oHpsDone, 1'b1);
    step();
    check("zero_start_2", oStartProcessing, 1'b0);
    hps_release("zero");
    check("zero_count", oRunCount, 16'd1);

    // ---- fast done: done in first START cycle, ready still high ----
    iSequencesToProcess = 8'd3;
    iReadyToProcess     = 1'b1;
    iHpsStart           = 1'b1;
    step();
    step();
    check("fast_start", oState, S_START);
    iDoneProcessing = 1'b1;
    step();
    check("fast_feedback", oState, S_FEEDBACK);
    iDoneProcessing = 1'b0;
    step();
    check("fast_report", oState, S_REPORT);
    check("fast_count", oRunCount, 16'd2);
    hps_release("fast");

    // ---- bring count to 5 ----
    quick_run("q3", 16'd3);
    quick_run("q4", 16'd4);
    quick_run("q5", 16'd5);

    // ---- reset mid-RUN ----
    iSequencesToProcess = 8'd7;
    iReadyToProcess     = 1'b1;
    iHpsStart           = 1'b1;
    step();
    step();
    iReadyToProcess = 1'b0;
    step();
    check("mid_run", oState, S_RUN);
    check("mid_count", oRunCount, 16'd5);
    iReset = 1'b1;
    step();
    iReset    = 1'b0;
    iHpsStart = 1'b0;
    check("mid_rst_state", oState, S_IDLE);
    check("mid_rst_busy", oBusy, 1'b0);
    check("mid_rst_count", oRunCount, 16'd0);
    check("mid_rst_seq", oSequencesToProcess, 8'd0);
    check("mid_rst_done", oHpsDone, 1'b0);
    check("mid_rst_start", oStartProcessing, 1'b0);
    check("mid_rst_feedback", oDoneProcessingFeedback, 1'b0);
    check("mid_rst_timeout", oTimeout, 1'b0);

    // ---- watchdog, ready held low ----
    iSequencesToProcess = 8'd4;
    iReadyToProcess     = 1'b0;
    iHpsStart           = 1'b1;
    step();
    check("wd_wait_ready", oState, S_WAIT_READY);
    for (int i = 0; i < 99; i++) step();
`ifdef CHROM_SCHED_TIMEOUT_EN
    check("wd_still_waiting", oState, S_WAIT_READY);
    check("wd_no_timeout_yet", oTimeout, 1'b0);
    step();
    check("wd_error", oState, S_ERROR);
    check("wd_timeout", oTimeout, 1'b1);
    check("wd_hps_done", oHpsDone, 1'b1);
    check("wd_start_low", oStartProcessing, 1'b0);
    iHpsAck = 1'b1;
    step();
    check("wd_release", oState, S_WAIT_RELEASE);
    check("wd_timeout_clear", oTimeout, 1'b0);
    iHpsStart = 1'b0;
    iHpsAck   = 1'b0;
    step();
    check("wd_idle", oState, S_IDLE);
    check("wd_idle_timeout", oTimeout, 1'b0);
    check("wd_count", oRunCount, 16'd0);
`else
    for (int i = 0; i < 50; i++) step();
    check("wd_off_waiting", oState, S_WAIT_READY);
    check("wd_off_timeout", oTimeout, 1'b0);
    iHpsStart = 1'b0;
    iReset    = 1'b1;
    step();
    iReset = 1'b0;
    check("wd_off_rst", oState, S_IDLE);
`endif

    // ---- saturation ----
    force dut.r_run_count = 16'hFFFE;
    step();
    release dut.r_run_count;
    step();
    check("sat_preload", oRunCount, 16'hFFFE);
    quick_run("sat1", 16'hFFFF);
    quick_run("sat2", 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
